// File: rtl/sr_cmd_sequencer.sv
// Command sequencer that drives a downstream SR flip-flop with HOLD/RESET/SET.
// Optional build macro: SR_CMD_SET_PRIORITY_EN (SET wins on conflicting requests).
module sr_cmd_sequencer #(
  parameter int MIN_DWELL = 4,
  parameter int DWELL_W   = 4,
  parameter int CONF_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_req,
  input  logic              reset_req,
  output logic [1:0]        cmd,
  output logic              q_mirror,
  output logic              busy,
  output logic [CONF_W-1:0] conflict_cnt
);

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_RESET = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;

  localparam logic [1:0] ST_LOW     = 2'd0;
  localparam logic [1:0] ST_HIGH    = 2'd1;
  localparam logic [1:0] ST_DWELL_H = 2'd2;
  localparam logic [1:0] ST_DWELL_L = 2'd3;

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
  localparam logic [CONF_W-1:0]  CONF_MAX   = '1;

  logic [1:0]         state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               q_mirror_q, q_mirror_d;
  logic               busy_q, busy_d;
  logic [CONF_W-1:0]  conf_q, conf_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               pend_set_q, pend_set_d;
  logic               pend_reset_q, pend_reset_d;

  logic conflict;
  logic eff_set;
  logic eff_reset;
  logic want_set;
  logic want_reset;

  assign conflict = set_req & reset_req;

`ifdef SR_CMD_SET_PRIORITY_EN
  assign eff_set   = set_req;
  assign eff_reset = reset_req & ~set_req;
`else
  assign eff_set   = set_req & ~reset_req;
  assign eff_reset = reset_req;
`endif

  // A same-direction request cancels an opposite pending one.
  assign want_set   = (pend_set_q | eff_set) & ~eff_reset;
  assign want_reset = (pend_reset_q | eff_reset) & ~eff_set;

  always_comb begin
    state_d      = state_q;
    cmd_d        = CMD_HOLD;
    dwell_d      = dwell_q;
    pend_set_d   = pend_set_q;
    pend_reset_d = pend_reset_q;
    unique case (state_q)
      ST_LOW: begin
        pend_set_d   = 1'b0;
        pend_reset_d = 1'b0;
        if (eff_set) begin
          cmd_d   = CMD_SET;
          state_d = ST_DWELL_H;
          dwell_d = DWELL_LOAD;
        end
      end
      ST_HIGH: begin
        pend_set_d   = 1'b0;
        pend_reset_d = 1'b0;
        if (eff_reset) begin
          cmd_d   = CMD_RESET;
          state_d = ST_DWELL_L;
          dwell_d = DWELL_LOAD;
        end
      end
      ST_DWELL_H: begin
        pend_set_d   = 1'b0;
        pend_reset_d = want_reset;
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else if (want_reset) begin
          cmd_d        = CMD_RESET;
          state_d      = ST_DWELL_L;
          dwell_d      = DWELL_LOAD;
          pend_reset_d = 1'b0;
        end else begin
          state_d      = ST_HIGH;
          pend_reset_d = 1'b0;
        end
      end
      ST_DWELL_L: begin
        pend_reset_d = 1'b0;
        pend_set_d   = want_set;
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else if (want_set) begin
          cmd_d      = CMD_SET;
          state_d    = ST_DWELL_H;
          dwell_d    = DWELL_LOAD;
          pend_set_d = 1'b0;
        end else begin
          state_d    = ST_LOW;
          pend_set_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  always_comb begin
    q_mirror_d = q_mirror_q;
    unique case (1'b1)
      cmd_q == CMD_SET:   q_mirror_d = 1'b1;
      cmd_q == CMD_RESET: q_mirror_d = 1'b0;
      default:            q_mirror_d = q_mirror_q;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_DWELL_H) || (state_d == ST_DWELL_L);
    conf_d = conf_q;
    if (conflict && (conf_q != CONF_MAX)) begin
      conf_d = conf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOW;
      cmd_q        <= CMD_HOLD;
      q_mirror_q   <= 1'b0;
      busy_q       <= 1'b0;
      conf_q       <= '0;
      dwell_q      <= '0;
      pend_set_q   <= 1'b0;
      pend_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      q_mirror_q   <= q_mirror_d;
      busy_q       <= busy_d;
      conf_q       <= conf_d;
      dwell_q      <= dwell_d;
      pend_set_q   <= pend_set_d;
      pend_reset_q <= pend_reset_d;
    end
  end

  assign cmd          = cmd_q;
  assign q_mirror     = q_mirror_q;
  assign busy         = busy_q;
  assign conflict_cnt = conf_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer (MIN_DWELL=4, CONF_W=8).
// Expected values follow SR_CMD_SET_PRIORITY_EN when it is defined.
module tb_sr_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       set_req;
  logic       reset_req;
  logic [1:0] cmd;
  logic       q_mirror;
  logic       busy;
  logic [7:0] conflict_cnt;

  typedef struct {
    logic [1:0] cmd;
    logic       q;
    logic       busy;
    int         cnt;
    int         id;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total  = 0;
  int    passed = 0;
  int    step_id = 0;

  sr_cmd_sequencer #(
    .MIN_DWELL(4),
    .DWELL_W(4),
    .CONF_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_req(set_req),
    .reset_req(reset_req),
    .cmd(cmd),
    .q_mirror(q_mirror),
    .busy(busy),
    .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic s, input logic x,
                      input logic [1:0] c, input logic qm,
                      input logic b, input int cn, input string nm);
    exp_t e;
    @(negedge clk);
    rst       = r;
    set_req   = s;
    reset_req = x;
    e.cmd  = c;
    e.q    = qm;
    e.busy = b;
    e.cnt  = cn;
    e.id   = step_id;
    step_id++;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: pops one expectation per sampled cycle and checks spacing.
  int cyc  = 0;
  int last = -1000;
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (cmd === e.cmd && q_mirror === e.q && busy === e.busy
            && int'(conflict_cnt) == e.cnt && !$isunknown(conflict_cnt)) begin
          passed++;
        end else begin
          $display("FAIL %s step %0d: got cmd=%b q=%b busy=%b cnt=%0d, want cmd=%b q=%b busy=%b cnt=%0d",
                   nm, e.id, cmd, q_mirror, busy, conflict_cnt,
                   e.cmd, e.q, e.busy, e.cnt);
        end
      end
      if (rst === 1'b1) begin
        last = -1000;
      end else if (cmd !== 2'b00) begin
        total++;
        if (cmd === 2'b11 || $isunknown(cmd) || (cyc - last) < 4) begin
          $display("FAIL spacing cycle %0d: got cmd=%b gap=%0d, want legal cmd gap>=4",
                   cyc, cmd, cyc - last);
        end else begin
          passed++;
        end
        last = cyc;
      end
    end
  end

  initial begin
    int c;
    rst       = 1'b1;
    set_req   = 1'b0;
    reset_req = 1'b0;

    step(1, 0, 0, 2'b00, 0, 0, 0, "reset0");
    step(1, 0, 0, 2'b00, 0, 0, 0, "reset1");
    step(0, 0, 0, 2'b00, 0, 0, 0, "idle");

    // Set pulse, full dwell, back to HIGH
    step(0, 1, 0, 2'b10, 0, 1, 0, "set_issue");
    step(0, 0, 0, 2'b00, 1, 1, 0, "set_dw1");
    step(0, 0, 0, 2'b00, 1, 1, 0, "set_dw2");
    step(0, 0, 0, 2'b00, 1, 1, 0, "set_dw3");
    step(0, 0, 0, 2'b00, 1, 0, 0, "high");

    // Reset pulse from HIGH
    step(0, 0, 1, 2'b01, 1, 1, 0, "rst_issue");
    step(0, 0, 0, 2'b00, 0, 1, 0, "rst_dw1");
    step(0, 0, 0, 2'b00, 0, 1, 0, "rst_dw2");
    step(0, 0, 0, 2'b00, 0, 1, 0, "rst_dw3");
    step(0, 0, 0, 2'b00, 0, 0, 0, "low");

    // Set then reset next edge: reset deferred to edge k+4
    step(0, 1, 0, 2'b10, 0, 1, 0, "pend_set");
    step(0, 0, 1, 2'b00, 1, 1, 0, "pend_capture");
    step(0, 0, 0, 2'b00, 1, 1, 0, "pend_wait1");
    step(0, 0, 0, 2'b00, 1, 1, 0, "pend_wait2");
    step(0, 0, 0, 2'b01, 1, 1, 0, "pend_issue");
    step(0, 0, 0, 2'b00, 0, 1, 0, "pend_dw1");
    step(0, 0, 0, 2'b00, 0, 1, 0, "pend_dw2");
    step(0, 0, 0, 2'b00, 0, 1, 0, "pend_dw3");
    step(0, 0, 0, 2'b00, 0, 0, 0, "pend_low");

    // Redundant set clears pending reset
    step(0, 1, 0, 2'b10, 0, 1, 0, "lw_set");
    step(0, 0, 1, 2'b00, 1, 1, 0, "lw_pend");
    step(0, 1, 0, 2'b00, 1, 1, 0, "lw_clear");
    step(0, 0, 0, 2'b00, 1, 1, 0, "lw_dw");
    step(0, 0, 0, 2'b00, 1, 0, 0, "lw_high");
    step(0, 0, 0, 2'b00, 1, 0, 0, "lw_hold");
    step(0, 0, 1, 2'b01, 1, 1, 0, "lw_rst");
    step(0, 0, 0, 2'b00, 0, 1, 0, "lw_rdw1");
    step(0, 0, 0, 2'b00, 0, 1, 0, "lw_rdw2");
    step(0, 0, 0, 2'b00, 0, 1, 0, "lw_rdw3");
    step(0, 0, 0, 2'b00, 0, 0, 0, "lw_low");

    // Conflict in LOW
`ifdef SR_CMD_SET_PRIORITY_EN
    step(0, 1, 1, 2'b10, 0, 1, 1, "conf_set");
    step(0, 0, 0, 2'b00, 1, 1, 1, "conf_dw1");
    step(0, 0, 0, 2'b00, 1, 1, 1, "conf_dw2");
    step(0, 0, 0, 2'b00, 1, 1, 1, "conf_dw3");
    step(0, 0, 0, 2'b00, 1, 0, 1, "conf_high");
    step(0, 0, 1, 2'b01, 1, 1, 1, "conf_rst");
    step(0, 0, 0, 2'b00, 0, 1, 1, "conf_rdw1");
    step(0, 0, 0, 2'b00, 0, 1, 1, "conf_rdw2");
    step(0, 0, 0, 2'b00, 0, 1, 1, "conf_rdw3");
    step(0, 0, 0, 2'b00, 0, 0, 1, "conf_low");
`else
    step(0, 1, 1, 2'b00, 0, 0, 1, "conf_drop");
    step(0, 0, 0, 2'b00, 0, 0, 1, "conf_low");
`endif

    // Reset mid-dwell with pending reset
    step(0, 1, 0, 2'b10, 0, 1, 1, "abort_set");
    step(0, 0, 1, 2'b00, 1, 1, 1, "abort_pend");
    step(0, 0, 0, 2'b00, 1, 1, 1, "abort_wait");
    step(1, 0, 0, 2'b00, 0, 0, 0, "abort_rst");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 2'b00, 0, 0, 0, "abort_quiet");
    end

    // Both requests held: saturation
    for (int i = 0; i < 300; i++) begin
      c = (i + 1 > 255) ? 255 : i + 1;
`ifdef SR_CMD_SET_PRIORITY_EN
      if (i == 0)
        step(0, 1, 1, 2'b10, 0, 1, c, "sat");
      else if (i < 4)
        step(0, 1, 1, 2'b00, 1, 1, c, "sat");
      else
        step(0, 1, 1, 2'b00, 1, 0, c, "sat");
`else
      step(0, 1, 1, 2'b00, 0, 0, c, "sat");
`endif
    end
`ifdef SR_CMD_SET_PRIORITY_EN
    step(0, 0, 0, 2'b00, 1, 0, 255, "sat_end");
`else
    step(0, 0, 0, 2'b00, 0, 0, 255, "sat_end");
`endif

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
